uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART receiver with parity. It sits between the raw serial pin, the receiver and the consuming logic. It generates the 16x oversampling tick, gates the receiver on and off at frame boundaries, and buffers received bytes in a small FIFO. It also accounts for parity errors and overflow.

---
 rtl/uart_rx_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling tick, frame-boundary gating and byte FIFO for a UART receiver.
// Build option: define UART_RX_PAR_DROP_EN to discard (but still count) bytes with parity errors.
module uart_rx_ctrl #(
    parameter int DVSR        = 163,
    parameter int DVSR_W      = 8,
    parameter int FIFO_AW     = 2,
    parameter int IDLE_TICKS  = 16,
    parameter int DRAIN_TICKS = 192
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               rx,
    output logic               rx_line,
    output logic               s_tick,
    input  logic               rx_done_tick,
    input  logic [7:0]         rx_dout,
    input  logic               rx_par_err,
    output logic               rd_valid,
    output logic [7:0]         rd_data,
    input  logic               rd_ack,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               busy,
    output logic               ovf,
    output logic               drain_to,
    output logic [7:0]         par_err_cnt,
    input  logic               clr_err
);
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int CNT_W   = FIFO_AW + 1;
    localparam int IDLE_W  = $clog2(IDLE_TICKS + 1);
    localparam int DRAIN_W = $clog2(DRAIN_TICKS + 1);
    localparam logic [DVSR_W-1:0]  DVSR_LAST  = DVSR_W'(DVSR - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TICKS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TICKS - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(DEPTH);

    typedef enum logic [1:0] {OFF, ARM, ACTIVE, DRAIN} state_t;
    state_t state, state_next;

    logic [DVSR_W-1:0]  div_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               inflight;
    logic               drain_expire;
    logic               accept, par_event, wr_req;
    logic               full, pop, push, ovf_event, head_empty;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
    logic [7:0]         mem [DEPTH];

    assign s_tick  = (state != OFF) && (div_cnt == DVSR_LAST);
    assign busy    = (state != OFF);
    assign rx_line = (state == ACTIVE || state == DRAIN) ? rx : 1'b1;

    always_comb begin
        state_next   = state;
        drain_expire = 1'b0;
        case (state)
            OFF:    if (en) state_next = ARM;
            ARM: begin
                if (!en)
                    state_next = OFF;
                else if (s_tick && rx && idle_cnt == IDLE_LAST)
                    state_next = ACTIVE;
            end
            ACTIVE: if (!en) state_next = inflight ? DRAIN : OFF;
            DRAIN: begin
                if (rx_done_tick) begin
                    state_next = OFF;
                end else if (s_tick && drain_cnt == DRAIN_LAST) begin
                    state_next   = OFF;
                    drain_expire = 1'b1;
                end
            end
            default: state_next = OFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= OFF;
        else        state <= state_next;
    end

    // Clearing on entry to OFF as well keeps the first tick exactly DVSR cycles after leaving OFF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            div_cnt <= '0;
        else if (state == OFF || state_next == OFF || s_tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DVSR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt  <= '0;
            drain_cnt <= '0;
            inflight  <= 1'b0;
        end else begin
            if (state != ARM || !rx)
                idle_cnt <= '0;
            else if (s_tick)
                idle_cnt <= idle_cnt + IDLE_W'(1);

            if (state != DRAIN)
                drain_cnt <= '0;
            else if (s_tick)
                drain_cnt <= drain_cnt + DRAIN_W'(1);

            if (state != ACTIVE || rx_done_tick)
                inflight <= 1'b0;
            else if (!rx)
                inflight <= 1'b1;
        end
    end

    assign accept    = rx_done_tick && (state == ACTIVE || state == DRAIN);
    assign par_event = accept && rx_par_err;
`ifdef UART_RX_PAR_DROP_EN
    assign wr_req    = accept && !rx_par_err;
`else
    assign wr_req    = accept;
`endif
    assign full       = (fifo_count == FULL_CNT);
    assign pop        = rd_ack && (fifo_count != '0);
    assign push       = wr_req && (!full || pop);
    assign ovf_event  = wr_req && full && !pop;
    assign rd_valid   = (fifo_count != '0);
    assign rd_ptr_inc = rd_ptr + FIFO_AW'(1);
    assign head_empty = (fifo_count == '0) || (pop && fifo_count == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_dout;
    end

    // rd_data mirrors the head: a byte landing in an empty FIFO bypasses memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rd_data    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push && head_empty)
                rd_data <= rx_dout;
            else if (pop)
                rd_data <= mem[rd_ptr_inc];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf         <= 1'b0;
            drain_to    <= 1'b0;
            par_err_cnt <= '0;
        end else begin
            if (ovf_event)    ovf <= 1'b1;
            else if (clr_err) ovf <= 1'b0;

            if (drain_expire) drain_to <= 1'b1;
            else if (clr_err) drain_to <= 1'b0;

            if (par_event) begin
                if (clr_err)
                    par_err_cnt <= 8'd1;
                else if (par_err_cnt != '1)
                    par_err_cnt <= par_err_cnt + 8'd1;
            end else if (clr_err) begin
                par_err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized scoreboard bench for uart_rx_ctrl; reference model is a byte queue plus error flags.
module tb_uart_rx_ctrl;
    localparam int DVSR        = 163;
    localparam int FIFO_AW     = 2;
    localparam int DEPTH       = 4;
    localparam int IDLE_TICKS  = 16;
    localparam int DRAIN_TICKS = 192;
`ifdef UART_RX_PAR_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             rx = 1'b1;
    logic             rx_done_tick = 1'b0;
    logic [7:0]       rx_dout = 8'h00;
    logic             rx_par_err = 1'b0;
    logic             rd_ack = 1'b0;
    logic             clr_err = 1'b0;
    logic             rx_line, s_tick, rd_valid, busy, ovf, drain_to;
    logic [7:0]       rd_data, par_err_cnt;
    logic [FIFO_AW:0] fifo_count;

    uart_rx_ctrl #(
        .DVSR(DVSR), .DVSR_W(8), .FIFO_AW(FIFO_AW),
        .IDLE_TICKS(IDLE_TICKS), .DRAIN_TICKS(DRAIN_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .rx(rx), .rx_line(rx_line), .s_tick(s_tick),
        .rx_done_tick(rx_done_tick), .rx_dout(rx_dout), .rx_par_err(rx_par_err),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ack(rd_ack), .fifo_count(fifo_count),
        .busy(busy), .ovf(ovf), .drain_to(drain_to), .par_err_cnt(par_err_cnt), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [7:0]  exp_q[$];
    bit          m_live = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_dto = 1'b0;
    int unsigned m_par = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endfunction

    // Scoreboard monitor: every honoured pop must present the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && rd_valid && rd_ack) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL pop_unexpected: got byte 0x%0h expected no byte", rd_data);
                end else begin
                    check("rd_data_pop", 32'(rd_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    function automatic void model_frame(input logic [7:0] d, input bit p, input bit ack, input bit clr);
        bit pop;
        pop = ack && (exp_q.size() != 0);
        if (clr) begin
            m_ovf = 1'b0;
            m_dto = 1'b0;
            m_par = 0;
        end
        if (!m_live) return;
        if (p) m_par = (m_par >= 255) ? 255 : m_par + 1;
        if (DROP && p) return;
        if (exp_q.size() >= DEPTH && !pop) m_ovf = 1'b1;
        else exp_q.push_back(d);
    endfunction

    function automatic void check_state(input string tag);
        check({tag, "_count"}, 32'(fifo_count), exp_q.size());
        check({tag, "_valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, "_head"}, 32'(rd_data), 32'(exp_q[0]));
        check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, "_drain_to"}, 32'(drain_to), 32'(m_dto));
        check({tag, "_par_cnt"}, 32'(par_err_cnt), m_par);
    endfunction

    function automatic void check_reset(input string tag);
        check({tag, "_rx_line"}, 32'(rx_line), 1);
        check({tag, "_s_tick"}, 32'(s_tick), 0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_rd_data"}, 32'(rd_data), 0);
        check({tag, "_fifo_count"}, 32'(fifo_count), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
        check({tag, "_drain_to"}, 32'(drain_to), 0);
        check({tag, "_par_cnt"}, 32'(par_err_cnt), 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n, input int unsigned mode);
        for (int unsigned i = 0; i < n; i++) begin
            rd_ack = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        rd_ack = 1'b0;
    endtask

    // One frame: a start-bit cycle on rx, then the receiver's completion pulse.
    task automatic send_frame(input logic [7:0] d, input bit p, input bit ack, input bit clr);
        rx = 1'b0;
        #1;
        check("rx_line_start", 32'(rx_line), m_live ? 0 : 1);
        step();
        rx = 1'b1;
        rx_done_tick = 1'b1;
        rx_dout = d;
        rx_par_err = p;
        rd_ack = ack;
        clr_err = clr;
        model_frame(d, p, ack, clr);
        step();
        rx_done_tick = 1'b0;
        rx_par_err = 1'b0;
        rd_ack = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        m_ovf = 1'b0;
        m_dto = 1'b0;
        m_par = 0;
        step();
        clr_err = 1'b0;
    endtask

    task automatic flush();
        int unsigned guard = 0;
        while (exp_q.size() != 0 && guard < 32) begin
            idle(1, 1);
            guard++;
        end
        check_state("flush");
    endtask

    task automatic arm();
        int unsigned cyc = 0;
        int unsigned nt = 0;
        int unsigned last = 0;
        bit per_ok = 1'b1;
        en = 1'b1;
        rx = 1'b1;
        while (nt < IDLE_TICKS && cyc < 4 * DVSR * IDLE_TICKS) begin
            @(negedge clk);
            if (s_tick) begin
                if (nt == 0) begin
                    check("first_tick_delay", cyc, DVSR);
                    check("arm_busy", 32'(busy), 1);
                end else if (cyc - last != DVSR) begin
                    per_ok = 1'b0;
                end
                last = cyc;
                nt++;
            end
            cyc++;
        end
        check("tick_period", 32'(per_ok), 1);
        check("arm_tick_count", nt, IDLE_TICKS);
        step();
        m_live = 1'b1;
    endtask

    initial begin
        int unsigned cyc;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        reset = 1'b1;
        step();
        check("busy_off", 32'(busy), 0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check_state("off_ignore");

        arm();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check("byte5a_data", 32'(rd_data), 32'h5A);
        check_state("byte5a");
        idle(1, 1);
        check_state("byte5a_pop");

        for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        check("ovf_fill_count", 32'(fifo_count), DEPTH);
        check("ovf_fill_flag", 32'(ovf), 1);
        check_state("ovf");
        send_frame(8'($urandom), 1'b0, 1'b1, 1'b0);
        check_state("full_pushpop");
        send_frame(8'($urandom), 1'b0, 1'b0, 1'b1);
        check_state("ovf_vs_clr");
        clear_errs();
        check_state("clr_ovf");
        send_frame(8'($urandom), 1'b0, 1'b1, 1'b0);
        check_state("full_pushpop_clean");
        flush();

        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        check("par33_cnt", 32'(par_err_cnt), 1);
        check("par33_count", 32'(fifo_count), DROP ? 0 : 1);
        check_state("par33");
        flush();
        clear_errs();

        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 3), 2);
            send_frame(8'($urandom), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'b0);
            check_state("rand");
        end
        flush();
        clear_errs();

        for (int i = 0; i < 258; i++) send_frame(8'($urandom), 1'b1, 1'b1, 1'b0);
        check("par_saturate", 32'(par_err_cnt), 255);
        send_frame(8'($urandom), 1'b1, 1'b1, 1'b1);
        check("par_clr_event", 32'(par_err_cnt), 1);
        check_state("par_sat");
        flush();

        // Disable mid-frame, re-request during DRAIN, finish the frame.
        rx = 1'b0;
        step();
        rx = 1'b1;
        en = 1'b0;
        step();
        check("drain_busy", 32'(busy), 1);
        en = 1'b1;
        idle(5, 0);
        check("drain_hold", 32'(busy), 1);
        d = 8'($urandom);
        rx_done_tick = 1'b1;
        rx_dout = d;
        rx_par_err = 1'b0;
        model_frame(d, 1'b0, 1'b0, 1'b0);
        step();
        rx_done_tick = 1'b0;
        check("drain_done_off", 32'(busy), 0);
        m_live = 1'b0;
        check_state("drain_done");

        arm();
        flush();

        // Disable mid-frame and let the drain window expire.
        rx = 1'b0;
        step();
        rx = 1'b1;
        en = 1'b0;
        step();
        cyc = 0;
        while (busy && cyc < (DRAIN_TICKS + 4) * DVSR) begin
            step();
            cyc++;
        end
        check("drain_to_exit", 32'(busy), 0);
        check("drain_to_time", 32'(cyc >= (DRAIN_TICKS - 1) * DVSR + 1 && cyc <= DRAIN_TICKS * DVSR + 2), 1);
        m_live = 1'b0;
        m_dto = 1'b1;
        check_state("drain_to");
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        check_state("off_ignore2");
        clear_errs();
        check_state("clr_dto");

        arm();
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        check_state("pre_reset");
        rx = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset("async_rst");
        exp_q.delete();
        m_live = 1'b0;
        m_ovf = 1'b0;
        m_dto = 1'b0;
        m_par = 0;
        rx = 1'b1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst_hold");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
